// File: rtl/cpu_pkg.sv
// Definitions shared by the CPU front-end blocks (PC, instruction memory, decode).
package cpu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 8;
  localparam int DEPTH_DEF  = 256;

  localparam logic [DATA_W_DEF-1:0] NOP = '0;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } imem_state_e;

endpackage

// File: rtl/imem_ram.sv
// Single-port synchronous RAM: one write or one registered read per cycle.
module imem_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // rdata only changes on a read, so it doubles as the held output word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/instr_mem_ctrl.sv
// Writable instruction memory: clear-on-reset sequencer, load port and a
// valid/ready fetch port with a registered, back-pressurable output.
module instr_mem_ctrl
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_valid,
  output logic              fetch_ready,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic              instr_fault,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_err,
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  imem_state_e       state_reg, state_next;
  logic [IDX_W-1:0]  clr_cnt_reg, clr_cnt_next;
  logic              instr_valid_reg, instr_valid_next;
  logic              instr_fault_reg, instr_fault_next;
  logic              instr_sel_reg, instr_sel_next;
  logic              load_err_reg, load_err_next;

  logic              ram_we;
  logic              ram_re;
  logic [IDX_W-1:0]  ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic              accept;
  logic              fetch_in_range;
  logic              load_in_range;

  // Unsigned full-width compare; DEPTH may equal 2**ADDR_W, so widen first.
  assign fetch_in_range = 32'(fetch_addr) < 32'(DEPTH);
  assign load_in_range  = 32'(load_addr)  < 32'(DEPTH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= CLEAR;
      clr_cnt_reg     <= '0;
      instr_valid_reg <= 1'b0;
      instr_fault_reg <= 1'b0;
      instr_sel_reg   <= 1'b0;
      load_err_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      clr_cnt_reg     <= clr_cnt_next;
      instr_valid_reg <= instr_valid_next;
      instr_fault_reg <= instr_fault_next;
      instr_sel_reg   <= instr_sel_next;
      load_err_reg    <= load_err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    clr_cnt_next  = clr_cnt_reg;
    load_err_next = 1'b0;
    fetch_ready   = 1'b0;
    ram_we        = 1'b0;
    ram_addr      = fetch_addr[IDX_W-1:0];
    ram_wdata     = load_data;
    unique case (state_reg)
      CLEAR: begin
        ram_we        = 1'b1;
        ram_addr      = clr_cnt_reg;
        ram_wdata     = DATA_W'(NOP);
        load_err_next = load_en;
        clr_cnt_next  = clr_cnt_reg + 1'b1;
        if (clr_cnt_reg == LAST_IDX) begin
          state_next = RUN;
        end
      end
      RUN: begin
        // Loads own the single RAM port, so they stall any fetch that cycle.
        fetch_ready = !load_en && (!instr_valid_reg || instr_ready);
        if (load_en) begin
          if (load_in_range) begin
            ram_we   = 1'b1;
            ram_addr = load_addr[IDX_W-1:0];
          end else begin
            load_err_next = 1'b1;
          end
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  assign accept = fetch_valid && fetch_ready;
  assign ram_re = accept && fetch_in_range;

  always_comb begin
    instr_valid_next = instr_valid_reg && !instr_ready;
    instr_fault_next = instr_fault_reg;
    instr_sel_next   = instr_sel_reg;
    if (accept) begin
      instr_valid_next = 1'b1;
      instr_fault_next = !fetch_in_range;
      instr_sel_next   = fetch_in_range;
    end
  end

  imem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // RAM read data is not reset; gate it until an in-range word was fetched.
  assign instr       = instr_sel_reg ? ram_rdata : DATA_W'(NOP);
  assign instr_valid = instr_valid_reg;
  assign instr_fault = instr_fault_reg;
  assign load_err    = load_err_reg;
  assign busy        = (state_reg == CLEAR);

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Scoreboard bench for instr_mem_ctrl: one DEPTH=256 and one DEPTH=16 instance.
module tb_instr_mem_ctrl;

  localparam int DW = 32;
  localparam int AW = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          fault;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          fv, le, ir;
  logic [AW-1:0] fa, la;
  logic [DW-1:0] ld;
  int            sel;

  logic [1:0]         fv_w, le_w;
  logic [1:0]         fr_w, iv_w, if_w, lerr_w, busy_w;
  logic [1:0][DW-1:0] instr_w;

  assign fv_w[0] = fv && (sel == 0);
  assign fv_w[1] = fv && (sel == 1);
  assign le_w[0] = le && (sel == 0);
  assign le_w[1] = le && (sel == 1);

  instr_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_valid(fv_w[0]), .fetch_ready(fr_w[0]), .fetch_addr(fa),
    .instr_valid(iv_w[0]), .instr_ready(ir), .instr(instr_w[0]), .instr_fault(if_w[0]),
    .load_en(le_w[0]), .load_addr(la), .load_data(ld),
    .load_err(lerr_w[0]), .busy(busy_w[0])
  );

  instr_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .fetch_valid(fv_w[1]), .fetch_ready(fr_w[1]), .fetch_addr(fa),
    .instr_valid(iv_w[1]), .instr_ready(ir), .instr(instr_w[1]), .instr_fault(if_w[1]),
    .load_en(le_w[1]), .load_addr(la), .load_data(ld),
    .load_err(lerr_w[1]), .busy(busy_w[1])
  );

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc_n = 0;
  bit   mon_en = 1'b0;
  exp_t q[$];

  logic [DW-1:0] mmem [2][256];
  logic          mrun [2];
  logic          mvalid [2];
  logic          mlerr [2];
  int            mclr [2];

  function automatic int depth_of(int d);
    return (d == 0) ? 256 : 16;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  // Reference model: compare current outputs, then advance to the next edge.
  always @(negedge clk) begin
    cyc_n++;
    for (int d = 0; d < 2; d++) begin
      logic exp_fr;
      logic inr;
      exp_t e;
      exp_fr = mrun[d] && !le_w[d] && (!mvalid[d] || ir);
      if (mon_en) begin
        check($sformatf("busy%0d", d), busy_w[d], !mrun[d]);
        check($sformatf("fetch_ready%0d", d), fr_w[d], exp_fr);
        check($sformatf("instr_valid%0d", d), iv_w[d], mvalid[d]);
        check($sformatf("load_err%0d", d), lerr_w[d], mlerr[d]);
        if (mvalid[d] && d == sel) begin
          if (q.size() == 0) begin
            check("sb_underflow", q.size(), 1);
          end else begin
            check($sformatf("instr%0d", d), instr_w[d], q[0].data);
            check($sformatf("fault%0d", d), if_w[d], q[0].fault);
          end
        end
      end
      if (!rst_n) begin
        mrun[d]   = 1'b0;
        mvalid[d] = 1'b0;
        mlerr[d]  = 1'b0;
        mclr[d]   = 0;
        if (d == sel) q.delete();
      end else begin
        if (mvalid[d] && ir && d == sel && q.size() > 0) begin
          $display("fetch dut%0d: instr=%08h fault=%0b", d, q[0].data, q[0].fault);
          void'(q.pop_front());
        end
        if (fv_w[d] && exp_fr) begin
          inr     = int'(fa) < depth_of(d);
          e.data  = inr ? mmem[d][fa] : '0;
          e.fault = !inr;
          q.push_back(e);
        end
        mvalid[d] = (fv_w[d] && exp_fr) || (mvalid[d] && !ir);
        mlerr[d]  = le_w[d] && (!mrun[d] || int'(la) >= depth_of(d));
        if (mrun[d] && le_w[d] && int'(la) < depth_of(d)) mmem[d][la] = ld;
        if (!mrun[d]) begin
          mmem[d][mclr[d]] = '0;
          if (mclr[d] == depth_of(d) - 1) mrun[d] = 1'b1;
          mclr[d]++;
        end
      end
    end
    if (!rst_n) mon_en = 1'b1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    le = 1'b1; la = a; ld = d;
    step(1);
    le = 1'b0;
  endtask

  // Leaves fetch_valid high so callers can chain fetches back-to-back.
  task automatic fetch(input logic [AW-1:0] a, output int acc_cyc);
    logic ok;
    ok = 1'b0; acc_cyc = -1;
    fa = a; fv = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (fr_w[sel]) begin
        ok = 1'b1; acc_cyc = cyc_n;
        break;
      end
      @(posedge clk); #1;
    end
    check("fetch_accept", ok, 1'b1);
    @(posedge clk); #1;
  endtask

  // Counts busy cycles of dut (DEPTH=256); optionally injects a load during CLEAR.
  task automatic count_busy(input int inj_at, output int n);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy_w[0]) break;
      n++;
      @(posedge clk); #1;
      le = (n == inj_at); la = 8'd3; ld = 32'hFFFF_FFFF;
    end
    le = 1'b0;
  endtask

  initial begin
    int n, c0, c1, cl;
    rst_n = 1'b0; fv = 1'b0; le = 1'b0; ir = 1'b1;
    fa = '0; la = '0; ld = '0; sel = 0;
    step(3);
    @(negedge clk);
    check("rst_busy", busy_w, 2'b11);
    check("rst_valid", iv_w, 2'b00);
    check("rst_fault", if_w, 2'b00);
    check("rst_lerr", lerr_w, 2'b00);
    check("rst_instr0", instr_w[0], 32'd0);
    check("rst_instr1", instr_w[1], 32'd0);
    @(posedge clk); #1;

    // Release with a fetch of address 5 pending; it is accepted on the first RUN cycle.
    fa = 8'd5; fv = 1'b1; rst_n = 1'b1;
    count_busy(50, n);
    check("busy_cycles", n, 256);
    check("first_accept", fr_w[0], 1'b1);
    @(posedge clk); #1;
    fv = 1'b0;
    step(3);

    load(8'd0, 32'h0C50_000A);
    load(8'd1, 32'h2B28_F000);
    fetch(8'd0, c0);
    fetch(8'd1, c1);
    fv = 1'b0;
    check("b2b_gap", c1 - c0, 1);
    step(3);

    // Backpressure: output holds while a new fetch waits.
    ir = 1'b0;
    fetch(8'd1, c0);
    fa = 8'd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_ready", fr_w[0], 1'b0);
      check("bp_hold", instr_w[0], 32'h2B28_F000);
      @(posedge clk); #1;
    end
    ir = 1'b1;
    @(negedge clk);
    check("bp_release", fr_w[0], 1'b1);
    @(posedge clk); #1;
    fv = 1'b0;
    step(3);

    // Load and fetch in the same cycle: load wins, fetch then sees new data.
    fa = 8'd7; fv = 1'b1; le = 1'b1; la = 8'd7; ld = 32'hDEAD_BEEF;
    @(negedge clk);
    check("ld_prio", fr_w[0], 1'b0);
    cl = cyc_n;
    @(posedge clk); #1;
    le = 1'b0;
    fetch(8'd7, c0);
    fv = 1'b0;
    check("raw_next", c0 - cl, 1);
    step(3);

    // DEPTH=16 instance: out-of-range fetch and load.
    sel = 1;
    step(1);
    fetch(8'd20, c0);
    fetch(8'd16, c0);
    fetch(8'd255, c0);
    fv = 1'b0;
    step(3);
    load(8'd16, 32'h1234_5678);
    @(negedge clk);
    check("lerr16", lerr_w[1], 1'b1);
    @(posedge clk); #1;
    fetch(8'd0, c0);
    load(8'd15, 32'hA5A5_5A5A);
    fetch(8'd15, c0);
    fv = 1'b0;
    step(3);

    // Reset at clear count 100 restarts the full clear.
    sel = 0;
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(100);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    count_busy(-1, n);
    check("busy_restart", n, 256);
    @(posedge clk); #1;
    fetch(8'd0, c0);
    fetch(8'd7, c0);
    fv = 1'b0;
    step(4);
    check("sb_drain", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc_n);
    $fatal(1, "timeout");
  end

endmodule
